// File: rtl/uart_pkg.sv
// uart_pkg
// Frame constants and shifter state type shared by the UART transmitter and
// receiver. Frames are 8N1, LSB first, with the line idling high.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_START_LVL = 1'b0;
    localparam logic UART_STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_tx_core_if.sv
// uart_tx_core_if
// Byte handshake between the producer (CPU I/O unit) and the UART transmitter.
//   TX_DATA  : byte to send (producer -> transmitter)
//   TX_VALID : TX_DATA is valid (producer -> transmitter)
//   TX_READY : transmitter can take a byte this cycle (transmitter -> producer)
// A byte moves on a rising edge with TX_VALID && TX_READY.
interface uart_tx_core_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] TX_DATA;
    logic                      TX_VALID;
    logic                      TX_READY;

    modport master (output TX_DATA, output TX_VALID, input TX_READY);
    modport slave  (input TX_DATA, input TX_VALID, output TX_READY);

endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Synchronous byte FIFO in front of the UART shifter.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   push/wdata : write a byte; ignored when full
//   pop/rdata  : rdata shows the head byte; pop discards it; ignored when empty
//   full/empty : occupancy flags
// Pointers carry one extra MSB so full and empty stay distinct after wrap.
// A push and a pop in the same cycle on an empty FIFO store the byte and
// leave the pop with nothing to take; there is no bypass path.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      push,
    input  logic [UART_DATA_BITS-1:0] wdata,
    input  logic                      pop,
    output logic [UART_DATA_BITS-1:0] rdata,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]               wr_ptr;
    logic [AW:0]               rd_ptr;
    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic                      do_push;
    logic                      do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// uart_tx_core
// UART transmitter (8N1, LSB first, idle high) for the CPU's UART_TX pin.
//   CLK     : clock, all logic on the rising edge
//   RST_N   : asynchronous active-low reset
//   tx      : byte handshake (TX_DATA / TX_VALID / TX_READY), slave side
//   UART_TX : registered serial line
//   BUSY    : frame in progress or a byte still buffered
// Build option UART_TX_FIFO_EN: when defined, a FIFO_DEPTH-entry byte FIFO
// buffers the input; otherwise a single holding register does, which still
// allows gap-free streaming (one byte held while another shifts).
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for one bit period
// DATA  | shift[0] on the line, 8 bit periods, LSB first
// STOP  | stop bit (high); chains straight into START if a byte is waiting
module uart_tx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 130,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    uart_tx_core_if.slave    tx,
    output logic             UART_TX,
    output logic             BUSY
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("CLKS_PER_BIT must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    uart_tx_state_t            state, state_d;
    logic [BAUD_W-1:0]         baud_cnt, baud_d;
    logic [BIT_W-1:0]          bit_cnt, bit_d;
    logic [UART_DATA_BITS-1:0] shift, shift_d;
    logic                      tx_q, tx_d;
    logic                      rdy_en;
    logic                      baud_end;

    logic                      push;
    logic                      pop;
    logic                      avail;
    logic                      buf_full;
    logic [UART_DATA_BITS-1:0] head_byte;

    // TX_READY stays low during reset and rises on the first edge after it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) rdy_en <= 1'b0;
        else        rdy_en <= 1'b1;
    end

    assign tx.TX_READY = rdy_en && !buf_full;
    assign push        = tx.TX_VALID && tx.TX_READY;

`ifdef UART_TX_FIFO_EN
    logic buf_empty;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .wdata (tx.TX_DATA),
        .pop   (pop),
        .rdata (head_byte),
        .full  (buf_full),
        .empty (buf_empty)
    );

    assign avail = !buf_empty;
`else
    logic                      hold_valid;
    logic [UART_DATA_BITS-1:0] hold_data;

    // push only happens while empty and pop only while full, so they never collide.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= tx.TX_DATA;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign buf_full  = hold_valid;
    assign avail     = hold_valid;
    assign head_byte = hold_data;
`endif

    assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= UART_STOP_LVL;
        end else begin
            state    <= state_d;
            baud_cnt <= baud_d;
            bit_cnt  <= bit_d;
            shift    <= shift_d;
            tx_q     <= tx_d;
        end
    end

    // tx_d is the level of the next cycle, so the line register changes on
    // the same edge as the state and UART_TX stays glitch-free.
    always_comb begin
        state_d = state;
        baud_d  = baud_cnt + BAUD_W'(1);
        bit_d   = bit_cnt;
        shift_d = shift;
        tx_d    = UART_STOP_LVL;
        pop     = 1'b0;

        unique case (state)
            IDLE: begin
                if (avail) begin
                    state_d = START;
                    pop     = 1'b1;
                    shift_d = head_byte;
                    tx_d    = UART_START_LVL;
                end
            end
            START: begin
                tx_d = UART_START_LVL;
                if (baud_end) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = shift[0];
                end
            end
            DATA: begin
                tx_d = shift[0];
                if (baud_end) begin
                    if (bit_cnt == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = UART_STOP_LVL;
                    end else begin
                        shift_d = shift >> 1;
                        bit_d   = bit_cnt + BIT_W'(1);
                        tx_d    = shift[1];
                    end
                end
            end
            STOP: begin
                tx_d = UART_STOP_LVL;
                if (baud_end) begin
                    if (avail) begin
                        state_d = START;
                        pop     = 1'b1;
                        shift_d = head_byte;
                        tx_d    = UART_START_LVL;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bit period restarts at every bit boundary and on every state change.
        if (baud_end || (state_d != state) || (state == IDLE)) begin
            baud_d = '0;
        end
    end

    assign UART_TX = tx_q;
    assign BUSY    = (state != IDLE) || avail;

endmodule

// File: tb/tb_uart_tx_core.sv
module tb_uart_tx_core;
    import uart_pkg::*;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic CLK;
    logic RST_N;
    logic UART_TX;
    logic BUSY;

    uart_tx_core_if tx_if();

    uart_tx_core #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .tx      (tx_if),
        .UART_TX (UART_TX),
        .BUSY    (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];
    int starts[$];
    int frames = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send(input logic [7:0] b, output int acc);
        int n;
        n = 0;
        tx_if.TX_DATA  = b;
        tx_if.TX_VALID = 1'b1;
        while (!tx_if.TX_READY && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        chk("send_accept_in_time", int'(tx_if.TX_READY), 1);
        acc = cyc + 1;
        exp_q.push_back(b);
        @(negedge CLK);
        tx_if.TX_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_in_time", int'(n < 3000), 1);
        repeat (3) @(negedge CLK);
    endtask

    // Monitor / receiver: captures every frame cycle-by-cycle and compares it
    // against the byte at the head of the scoreboard.
    initial begin
        logic [FRAME-1:0] lv;
        logic [7:0]       exp_b;
        logic [7:0]       got_b;
        int               mism;
        int               st;
        bit               aborted;
        forever begin
            @(negedge CLK);
            if (RST_N && UART_TX == 1'b0) begin
                st      = cyc;
                lv      = '0;
                aborted = 1'b0;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge CLK);
                    if (!RST_N) begin
                        aborted = 1'b1;
                        break;
                    end
                    lv[i] = UART_TX;
                end
                if (!aborted) begin
                    starts.push_back(st);
                    frames++;
                    for (int k = 0; k < 8; k++) got_b[k] = lv[(k + 1) * CPB + CPB / 2];
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", int'(got_b), -1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        mism  = 0;
                        for (int i = 0; i < FRAME; i++) begin
                            int  b;
                            logic want;
                            b = i / CPB;
                            if (b == 0)      want = 1'b0;
                            else if (b == 9) want = 1'b1;
                            else             want = exp_b[b - 1];
                            if (lv[i] != want) mism++;
                        end
                        chk("rx_byte", int'(got_b), int'(exp_b));
                        chk("frame_shape_bad_cycles", mism, 0);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream_v[3];
        int a0, a1, a2, n_low, f0;

        stream_v[0] = 8'h00;
        stream_v[1] = 8'hFF;
        stream_v[2] = 8'h3C;

        tx_if.TX_VALID = 1'b0;
        tx_if.TX_DATA  = 8'h00;
        RST_N          = 1'b0;

        // 1: reset values and TX_READY release timing
        repeat (3) @(negedge CLK);
        chk("rst_uart_tx", int'(UART_TX), 1);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_tx_ready", int'(tx_if.TX_READY), 0);
        RST_N = 1'b1;
        #1;
        chk("release_ready_before_edge", int'(tx_if.TX_READY), 0);
        @(posedge CLK);
        #1;
        chk("release_ready_after_edge", int'(tx_if.TX_READY), 1);
        @(negedge CLK);

        // 2: single byte 0xA5, latency and BUSY timing
        starts.delete();
        send(8'hA5, a0);
        chk("busy_after_accept", int'(BUSY), 1);
        while (cyc < a0 + FRAME) @(negedge CLK);
        chk("busy_last_stop_cycle", int'(BUSY), 1);
        @(negedge CLK);
        chk("busy_after_frame", int'(BUSY), 0);
        chk("line_idle_after_frame", int'(UART_TX), 1);
        drain();
        chk("a5_frames", starts.size(), 1);
        if (starts.size() >= 1) chk("a5_start_latency", starts[0] - a0, 1);

        // 3: back-to-back stream, no idle gap
        starts.delete();
        send(stream_v[0], a0);
        for (int i = 1; i < 3; i++) send(stream_v[i], a1);
        drain();
        chk("stream_frames", starts.size(), 3);
        if (starts.size() == 3) begin
            chk("stream_first_latency", starts[0] - a0, 1);
            chk("stream_gap_0_1", starts[1] - starts[0], FRAME);
            chk("stream_gap_1_2", starts[2] - starts[1], FRAME);
        end

`ifdef UART_TX_FIFO_EN
        // 4: fill the FIFO during the first frame; 17 bytes with pointer wrap
        send(8'h5A, a0);
        for (int i = 1; i < 17; i++) send(8'((i * 37 + 5) & 8'hFF), a1);
        chk("fifo_last_accept_cycle", a1 - a0, 16);
        chk("fifo_full_ready_low", int'(tx_if.TX_READY), 0);
        chk("fifo_full_busy", int'(BUSY), 1);
        drain();
        chk("fifo_all_emitted", exp_q.size(), 0);
`else
        // 5: holding register accepts one byte while another shifts
        send(8'h12, a0);
        send(8'h34, a1);
        chk("hold_second_accept", a1 - a0, 2);
        chk("hold_full_ready_low", int'(tx_if.TX_READY), 0);
        send(8'h56, a2);
        chk("hold_third_accept", a2 - a0, 42);
        drain();
`endif

        // 6: reset during DATA bit 3 of 0x55 with bytes queued
        send(8'h55, a0);
        send(8'h66, a1);
`ifdef UART_TX_FIFO_EN
        send(8'h77, a2);
`endif
        while (cyc < a0 + 18) @(negedge CLK);
        chk("mid_frame_bit3_low", int'(UART_TX), 0);
        f0 = frames;
        RST_N = 1'b0;
        #1;
        chk("rst_mid_uart_tx", int'(UART_TX), 1);
        chk("rst_mid_busy", int'(BUSY), 0);
        chk("rst_mid_ready", int'(tx_if.TX_READY), 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        n_low = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (UART_TX == 1'b0) n_low++;
        end
        chk("post_rst_line_low_cycles", n_low, 0);
        chk("post_rst_busy", int'(BUSY), 0);
        chk("post_rst_frames", frames - f0, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
